// File: rtl/rv_pkg.sv
// Shared RV32I decode-stage definitions: opcodes, bubble encoding, sequencer states, J-immediate.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LU_STALL,
    ST_FLUSH
  } issue_state_e;

  // Sign-extended J-type immediate of a JAL instruction.
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect: the instruction in ID reads a register that the load in EX writes.
module hazard_unit
  import rv_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       lu_hazard
);

  logic use_rs1;
  logic use_rs2;

  // Decode which source fields the opcode actually reads, then compare against the load target.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: use_rs1 = 1'b1;
      OPC_STORE, OPC_OP, OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
    lu_hazard = id_valid & ex_is_load & (ex_rd != '0) &
                ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));
  end

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage sequencer: owns IF/ID, resolves load-use stalls and JAL/EX redirects, counts events.
module issue_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter logic [31:0] NOP_INSTR    = rv_pkg::NOP_INSTR
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_valid_i,
  input  logic [31:0]      if_instr_i,
  input  logic [31:0]      if_pc_i,
  output logic             if_ready_o,
  output logic             id_valid_o,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc_o,
  output logic             id_bubble_o,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_redirect_i,
  input  logic [31:0]      ex_target_i,
  output logic             pc_stall_o,
  output logic             pc_redirect_o,
  output logic [31:0]      pc_target_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [2:0]   FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam issue_state_e REDIR_NEXT = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;

  issue_state_e     state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic             id_valid_q;
  logic [31:0]      id_instr_q;
  logic [31:0]      id_pc_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic             lu_hazard;
  logic             ld_bubble;
  logic             ld_fetch;
  logic             stall_inc;
  logic             flush_inc;

  hazard_unit u_hazard (
    .id_valid   (id_valid_q),
    .opcode     (id_instr_q[6:0]),
    .rs1        (id_instr_q[19:15]),
    .rs2        (id_instr_q[24:20]),
    .ex_is_load (ex_is_load_i),
    .ex_rd      (ex_rd_i),
    .lu_hazard  (lu_hazard)
  );

  // Event priority and next-state: EX redirect > load-use > JAL in ID > flush drain > advance.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    if_ready_o    = 1'b1;
    pc_stall_o    = 1'b0;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    id_bubble_o   = 1'b0;
    ld_bubble     = 1'b0;
    ld_fetch      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (ex_redirect_i) begin
      pc_redirect_o = 1'b1;
      pc_target_o   = ex_target_i;
      id_bubble_o   = 1'b1;
      ld_bubble     = 1'b1;
      flush_inc     = 1'b1;
      fcnt_d        = FLUSH_INIT;
      state_d       = REDIR_NEXT;
    end else if ((state_q == ST_RUN) && lu_hazard) begin
      if_ready_o    = 1'b0;
      pc_stall_o    = 1'b1;
      id_bubble_o   = 1'b1;
      stall_inc     = 1'b1;
      state_d       = ST_LU_STALL;
    end else if ((state_q == ST_RUN) && id_valid_q && (id_instr_q[6:0] == OPC_JAL)) begin
      pc_redirect_o = 1'b1;
      pc_target_o   = id_pc_q + j_imm(id_instr_q);
      ld_bubble     = 1'b1;
      flush_inc     = 1'b1;
      fcnt_d        = FLUSH_INIT;
      state_d       = REDIR_NEXT;
    end else if (state_q == ST_FLUSH) begin
      ld_bubble     = 1'b1;
      fcnt_d        = fcnt_q - 3'd1;
      if (fcnt_q <= 3'd1) state_d = ST_RUN;
    end else begin
      ld_fetch      = 1'b1;
      state_d       = ST_RUN;
    end
  end

  // Sequencer state and flush down-counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // IF/ID register: bubble on redirect/flush, load fetch on advance, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
    end else if (ld_bubble) begin
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
    end else if (ld_fetch) begin
      id_valid_q <= if_valid_i;
      id_instr_q <= if_valid_i ? if_instr_i : NOP_INSTR;
      id_pc_q    <= if_pc_i;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign id_valid_o  = id_valid_q;
  assign id_instr_o  = id_instr_q;
  assign id_pc_o     = id_pc_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_issue_ctrl;

  localparam int FLUSH = 1;

  logic        clk = 1'b0;
  logic        rst_i, if_valid_i, ex_is_load_i, ex_redirect_i;
  logic [31:0] if_instr_i, if_pc_i, ex_target_i;
  logic [4:0]  ex_rd_i;

  logic        if_ready_o, id_valid_o, id_bubble_o, pc_stall_o, pc_redirect_o;
  logic [31:0] id_instr_o, id_pc_o, pc_target_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic        d2_if_ready, d2_id_valid, d2_id_bubble, d2_pc_stall, d2_pc_redirect;
  logic [31:0] d2_id_instr, d2_id_pc, d2_pc_target;
  logic [1:0]  d2_stall_cnt, d2_flush_cnt;

  always #5 clk = ~clk;

  issue_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(16), .NOP_INSTR(32'h00000013)) dut (
    .clk_i(clk), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
    .if_pc_i(if_pc_i), .if_ready_o(if_ready_o), .id_valid_o(id_valid_o),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_bubble_o(id_bubble_o),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .ex_redirect_i(ex_redirect_i),
    .ex_target_i(ex_target_i), .pc_stall_o(pc_stall_o), .pc_redirect_o(pc_redirect_o),
    .pc_target_o(pc_target_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  issue_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
    .if_pc_i(if_pc_i), .if_ready_o(d2_if_ready), .id_valid_o(d2_id_valid),
    .id_instr_o(d2_id_instr), .id_pc_o(d2_id_pc), .id_bubble_o(d2_id_bubble),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .ex_redirect_i(ex_redirect_i),
    .ex_target_i(ex_target_i), .pc_stall_o(d2_pc_stall), .pc_redirect_o(d2_pc_redirect),
    .pc_target_o(d2_pc_target), .stall_cnt_o(d2_stall_cnt), .flush_cnt_o(d2_flush_cnt)
  );

  typedef struct {
    logic        ready, valid, bubble, stall, redir;
    logic [31:0] instr, pc, target;
    int          stalls, flushes;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: pipeline register contents plus "cycles still to drop" and "just stalled".
  bit          m_valid;
  logic [31:0] m_instr, m_pc;
  int          m_drop, m_stalls, m_flushes;
  bit          m_after;

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0100011, 7'b0110011, 7'b1100011};
  endfunction

  function automatic logic [31:0] jal_offset(input logic [31:0] i);
    int v;
    v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
    if (i[31]) v = v - 1048576;
    return 32'(v);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_instr = 32'h13; m_pc = 0;
    m_drop = 0; m_after = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic squash();
    m_valid = 0; m_instr = 32'h13; m_pc = 0;
  endtask

  // One clock of stimulus: drive inputs, predict this cycle's outputs, queue them, advance model.
  task automatic step(input bit rst, input bit fv, input logic [31:0] fi, input logic [31:0] fp,
                      input bit ld, input logic [4:0] rd, input bit rdr, input logic [31:0] tgt);
    exp_t e;
    bit   hz, free;
    logic [6:0] op;
    @(posedge clk); #1;
    rst_i = rst; if_valid_i = fv; if_instr_i = fi; if_pc_i = fp;
    ex_is_load_i = ld; ex_rd_i = rd; ex_redirect_i = rdr; ex_target_i = tgt;
    e.valid = m_valid; e.instr = m_instr; e.pc = m_pc;
    e.stalls = m_stalls; e.flushes = m_flushes;
    e.ready = 1; e.bubble = 0; e.stall = 0; e.redir = 0; e.target = 0;
    op = m_instr[6:0];
    hz = m_valid && ld && (rd != 0) &&
         ((reads_rs1(op) && m_instr[19:15] == rd) || (reads_rs2(op) && m_instr[24:20] == rd));
    free = (m_drop == 0) && !m_after;
    if (rdr) begin
      e.redir = 1; e.target = tgt; e.bubble = 1;
      squash(); m_flushes++; m_drop = FLUSH; m_after = 0;
    end else if (free && hz) begin
      e.ready = 0; e.stall = 1; e.bubble = 1;
      m_stalls++; m_after = 1;
    end else if (free && m_valid && op == 7'b1101111) begin
      e.redir = 1; e.target = m_pc + jal_offset(m_instr);
      squash(); m_flushes++; m_drop = FLUSH;
    end else if (m_drop > 0) begin
      squash(); m_drop--;
    end else begin
      m_valid = fv; m_instr = fv ? fi : 32'h13; m_pc = fp; m_after = 0;
    end
    if (rst) model_reset();
    q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] fi, input logic [31:0] fp);
    step(0, 1, fi, fp, 0, 5'd0, 0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 32'h0, 32'h0, 0, 5'd0, 0, 32'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the oldest queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("if_ready", 32'(if_ready_o), 32'(e.ready));
      chk("id_valid", 32'(id_valid_o), 32'(e.valid));
      chk("id_instr", id_instr_o, e.instr);
      if (e.valid) chk("id_pc", id_pc_o, e.pc);
      chk("id_bubble", 32'(id_bubble_o), 32'(e.bubble));
      chk("pc_stall", 32'(pc_stall_o), 32'(e.stall));
      chk("pc_redirect", 32'(pc_redirect_o), 32'(e.redir));
      chk("pc_target", pc_target_o, e.target);
      chk("stall_cnt", 32'(stall_cnt_o), 32'(sat(e.stalls, 65535)));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(sat(e.flushes, 65535)));
      chk("stall_cnt_w2", 32'(d2_stall_cnt), 32'(sat(e.stalls, 3)));
      chk("flush_cnt_w2", 32'(d2_flush_cnt), 32'(sat(e.flushes, 3)));
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 8))
      0: w[6:0] = 7'b0000011;
      1: w[6:0] = 7'b0100011;
      2: w[6:0] = 7'b0010011;
      3: w[6:0] = 7'b0110011;
      4: w[6:0] = 7'b1100011;
      5: w[6:0] = 7'b1101111;
      6: w[6:0] = 7'b1100111;
      7: w[6:0] = 7'b0110111;
      default: w[6:0] = 7'b0010111;
    endcase
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  localparam logic [31:0] ADD_X3 = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] LUI_X1 = 32'h001080B7;  // lui x1 with rs1/rs2 bit-fields = 1
  localparam logic [31:0] JAL_M8 = 32'hFF9FF06F;  // jal x0,-8

  initial begin
    logic [31:0] pc;
    rst_i = 1; if_valid_i = 0; if_instr_i = 0; if_pc_i = 0;
    ex_is_load_i = 0; ex_rd_i = 0; ex_redirect_i = 0; ex_target_i = 0;
    @(posedge clk);
    model_reset();

    // Reset held with fetch valid.
    step(1, 1, 32'hDEADBEEF, 32'h40, 0, 5'd0, 0, 32'd0);
    step(1, 1, 32'hDEADBEEF, 32'h44, 0, 5'd0, 0, 32'd0);

    // Load-use stall then single-cycle advance.
    fetch(ADD_X3, 32'h10);
    step(0, 1, 32'h00000013, 32'h14, 1, 5'd1, 0, 32'd0);
    step(0, 1, 32'h00000013, 32'h14, 1, 5'd1, 0, 32'd0);
    idle(1);

    // No stall: rd=0, and LUI with matching field bits.
    fetch(ADD_X3, 32'h20);
    step(0, 1, LUI_X1, 32'h24, 1, 5'd0, 0, 32'd0);
    step(0, 1, 32'h00000013, 32'h28, 1, 5'd1, 0, 32'd0);

    // JAL in ID at 0x100 with offset -8, then flush window.
    fetch(JAL_M8, 32'h100);
    fetch(32'h11111111, 32'h104);
    fetch(32'h22222222, 32'h108);
    fetch(32'h33333333, 32'h0F8);
    idle(1);

    // EX redirect coinciding with load-use, then with JAL in ID.
    fetch(ADD_X3, 32'h30);
    step(0, 1, 32'h0, 32'h34, 1, 5'd1, 1, 32'h200);
    idle(2);
    fetch(JAL_M8, 32'h100);
    step(0, 1, 32'h0, 32'h104, 1, 5'd3, 1, 32'h200);
    idle(2);

    // Five stalls to saturate the narrow counters.
    for (int k = 0; k < 5; k++) begin
      fetch(ADD_X3, 32'h400 + 32'(k * 4));
      step(0, 0, 32'h0, 32'h0, 1, 5'd2, 0, 32'd0);
      idle(1);
    end

    // Reset asserted during the flush window.
    fetch(JAL_M8, 32'h100);
    idle(1);
    step(1, 0, 32'h0, 32'h0, 0, 5'd0, 0, 32'd0);
    fetch(ADD_X3, 32'h500);
    idle(1);

    // Randomized traffic.
    pc = 32'h1000;
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_instr(), pc,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           ($urandom_range(0, 11) == 0), $urandom);
      pc = pc + 32'd4;
    end

    @(posedge clk);
    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
